// File: rtl/stochastic_decoder.sv
// stochastic_decoder: counts 1s over a window of LENGTH accepted samples.
// Optional free-running mode: define STOCH_DECODER_AUTORESTART_EN.
module stochastic_decoder #(
    parameter int LENGTH = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    output logic                          busy,
    output logic [$clog2(LENGTH+1)-1:0]   result,
    output logic                          result_valid
);

    localparam int CW = $clog2(LENGTH + 1);
    localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] n_q, n_d;
    logic [CW-1:0] ones_q, ones_d;
    logic [CW-1:0] res_q, res_d;
    logic          rv_q, rv_d;

    // State, counters and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            ones_q  <= '0;
            res_q   <= '0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            ones_q  <= ones_d;
            res_q   <= res_d;
            rv_q    <= rv_d;
        end
    end

    // Next-state: window start, sample accumulation, completion
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        ones_d  = ones_q;
        res_d   = res_q;
        rv_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    n_d     = '0;
                    ones_d  = '0;
                end
            end
            ACCUM: begin
                if (bit_valid) begin
                    if (n_q == LAST) begin
                        // last sample folds straight into the result
                        res_d  = ones_q + CW'(bit_in);
                        rv_d   = 1'b1;
                        n_d    = '0;
                        ones_d = '0;
`ifdef STOCH_DECODER_AUTORESTART_EN
                        state_d = ACCUM;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        n_d    = n_q + 1'b1;
                        ones_d = ones_q + CW'(bit_in);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy         = (state_q == ACCUM);
    assign result       = res_q;
    assign result_valid = rv_q;

endmodule

// File: tb/tb_stochastic_decoder.sv
// tb_stochastic_decoder: random and directed checks against a
// queue-based window model of the decoder.
module tb_stochastic_decoder;

    localparam int LENGTH = 16;
    localparam int CW = $clog2(LENGTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          bit_in;
    logic          bit_valid;
    logic          busy;
    logic [CW-1:0] result;
    logic          result_valid;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: window of accepted samples
    bit m_busy;
    int m_res;
    bit m_rv;
    bit win[$];

    stochastic_decoder #(.LENGTH(LENGTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid)
    );

    // free-running clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got,
                         input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int win_sum();
        int s = 0;
        foreach (win[i]) s += int'(win[i]);
        return s;
    endfunction

    task automatic model_edge(input bit s, input bit b,
                              input bit v);
        m_rv = 1'b0;
        if (!m_busy) begin
            if (s) begin
                m_busy = 1'b1;
                win.delete();
            end
        end else if (v) begin
            win.push_back(b);
            if (win.size() == LENGTH) begin
                m_res = win_sum();
                m_rv  = 1'b1;
                win.delete();
`ifndef STOCH_DECODER_AUTORESTART_EN
                m_busy = 1'b0;
`endif
            end
        end
    endtask

    // one clock: drive, clock, model, compare
    task automatic cyc(input bit s, input bit b, input bit v);
        start     = s;
        bit_in    = b;
        bit_valid = v;
        @(posedge clk);
        model_edge(s, b, v);
        #1;
        check("busy", int'(busy), int'(m_busy));
        check("result", int'(result), m_res);
        check("result_valid", int'(result_valid), int'(m_rv));
    endtask

    task automatic async_reset();
        #3 rst = 1'b1;
        #1;
        m_busy = 1'b0;
        m_res  = 0;
        m_rv   = 1'b0;
        win.delete();
        check("rst_busy", int'(busy), 0);
        check("rst_result", int'(result), 0);
        check("rst_rv", int'(result_valid), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_hold_rv", int'(result_valid), 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        int k;
        int exp;
        bit b;
        rst       = 1'b1;
        start     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        m_busy    = 1'b0;
        m_res     = 0;
        m_rv      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_result", int'(result), 0);
        check("reset_rv", int'(result_valid), 0);
        rst = 1'b0;
        cyc(0, 0, 0);

`ifndef STOCH_DECODER_AUTORESTART_EN
        // all-ones window with latency
        cyc(1, 1, 1);
        k = 0;
        for (int i = 1; i <= 3 * LENGTH; i++) begin
            cyc(0, 1, 1);
            if (result_valid) begin
                k = i;
                break;
            end
        end
        check("ones_latency", k, LENGTH);
        check("ones_result", int'(result), LENGTH);
        check("ones_busy", int'(busy), 0);
        cyc(0, 1, 1);
        check("ones_single_pulse", int'(result_valid), 0);

        // alternating then all-zeros, result held between
        cyc(1, 0, 0);
        for (int i = 0; i < LENGTH; i++) cyc(0, (i % 2) == 0, 1);
        check("alt_result", int'(result), LENGTH / 2);
        repeat (3) cyc(0, 1, 0);
        check("alt_hold", int'(result), LENGTH / 2);
        cyc(1, 0, 0);
        for (int i = 0; i < LENGTH; i++) cyc(0, 0, 1);
        check("zeros_result", int'(result), 0);

        // gapped valid
        cyc(1, 1, 1);
        k = 0;
        for (int i = 1; i <= 4 * LENGTH; i++) begin
            cyc(0, 1, (i % 2) == 1);
            if (result_valid) begin
                k = i;
                break;
            end
        end
        check("gap_latency", k, 2 * LENGTH - 1);
        check("gap_result", int'(result), LENGTH);

        // start-edge bit ignored, mid-window start ignored
        cyc(1, 1, 1);
        exp = 0;
        for (int i = 0; i < LENGTH; i++) begin
            b = i % 3 == 0;
            exp += int'(b);
            cyc(i == 5, b, 1);
        end
        check("start_edge_result", int'(result), exp);
        check("start_edge_rv", int'(result_valid), 1);

        // reset after 7 samples, then a fresh window
        cyc(1, 1, 1);
        for (int i = 0; i < 7; i++) cyc(0, 1, 1);
        async_reset();
        cyc(1, 0, 0);
        exp = 0;
        for (int i = 0; i < LENGTH; i++) begin
            b = 1'($urandom_range(0, 1));
            exp += int'(b);
            cyc(0, b, 1);
        end
        check("post_rst_result", int'(result), exp);
`else
        // free-running: pulses every LENGTH samples, busy stays high
        cyc(1, 0, 0);
        k = 0;
        for (int i = 1; i <= 3 * LENGTH; i++) begin
            cyc(0, 1'($urandom_range(0, 1)), 1);
            check("ar_busy", int'(busy), 1);
            if (result_valid) begin
                k++;
                check("ar_pulse_pos", i % LENGTH, 0);
            end
        end
        check("ar_pulses", k, 3);
        async_reset();
        cyc(0, 0, 0);
`endif

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 9) == 0,
                1'($urandom_range(0, 1)),
                $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
